// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline defines: hold/flush levels from the control unit, the NOP
// bubble encoding and the squash helper used by every pipeline boundary register.
package pipe_stage_reg_pkg;

    localparam int unsigned HOLD_W = 3;
    localparam int unsigned OCC_W  = 2;

    // Hold level at which the instruction-decode boundary is flushed
    localparam logic [HOLD_W-1:0] HOLD_ID = 3'd3;

    // addi x0, x0, 0 -- the canonical RISC-V NOP
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // A boundary is squashed when the control unit's hold level reaches its threshold
    function automatic logic is_squash(input logic [HOLD_W-1:0] hold,
                                       input logic [HOLD_W-1:0] level);
        return hold >= level;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake and hold-driven squash.
// Invalid slots always carry the NOP bubble so downstream decode sees a NOP.
//
// Build option: PIPE_SKID_EN adds a skid entry behind the main register, giving
// a registered ready_o and full throughput; without it only the main register
// exists and ready_o is combinational.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   hold_flag_i - hold/flush level from the control unit
//   valid_i     - upstream payload valid
//   data_i      - upstream payload (concatenated bundle, DW bits)
//   ready_o     - stage accepts a payload this cycle
//   valid_o     - downstream payload valid
//   data_o      - downstream payload, NOP when not valid
//   ready_i     - downstream accepts a payload this cycle
//   occ_o       - number of payloads held (0..2)
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DW         = 32,
    parameter logic [31:0]       NOP_VAL    = NOP_INST,
    parameter logic [HOLD_W-1:0] HOLD_LEVEL = HOLD_ID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              valid_i,
    input  logic [DW-1:0]     data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    input  logic              ready_i,
    output logic [OCC_W-1:0]  occ_o
);

    localparam logic [DW-1:0] NOP_DW = DW'(NOP_VAL);

    logic             squash;
    logic             up_xfer;
    logic             down_xfer;

    logic             main_valid_q, main_valid_d;
    logic [DW-1:0]    main_data_q,  main_data_d;
    logic [OCC_W-1:0] occ_q,        occ_d;

`ifdef PIPE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [DW-1:0]    skid_data_q,  skid_data_d;
    logic             ready_q,      ready_d;
`else
    logic             rst_done_q;
`endif

    assign squash    = is_squash(hold_flag_i, HOLD_LEVEL);
    assign down_xfer = main_valid_q & ready_i;
    assign up_xfer   = valid_i & ready_o;

`ifdef PIPE_SKID_EN
    // Space is known a cycle ahead; squash still blocks acceptance immediately
    assign ready_o = ready_q & ~squash;
`else
    // rst_done_q keeps ready low until the first edge after reset release
    assign ready_o = rst_done_q & ~squash & (~main_valid_q | ready_i);
`endif

    assign valid_o = main_valid_q;
    assign data_o  = main_data_q;
    assign occ_o   = occ_q;

    // Next-state: pop the head on a downstream transfer, then place any new
    // payload in the first free slot. Empty slots are refilled with NOP.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
`ifdef PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
`endif

        if (squash) begin
            main_valid_d = 1'b0;
            main_data_d  = NOP_DW;
`ifdef PIPE_SKID_EN
            skid_valid_d = 1'b0;
            skid_data_d  = NOP_DW;
`endif
        end else begin
            if (down_xfer) begin
`ifdef PIPE_SKID_EN
                // Skid entry (or its NOP filler) advances into the main register
                main_valid_d = skid_valid_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = NOP_DW;
`else
                main_valid_d = 1'b0;
                main_data_d  = NOP_DW;
`endif
            end
            if (up_xfer) begin
`ifdef PIPE_SKID_EN
                if (!main_valid_d) begin
                    main_valid_d = 1'b1;
                    main_data_d  = data_i;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = data_i;
                end
`else
                main_valid_d = 1'b1;
                main_data_d  = data_i;
`endif
            end
        end

`ifdef PIPE_SKID_EN
        occ_d   = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
        ready_d = (occ_d < OCC_W'(2));
`else
        occ_d   = OCC_W'(main_valid_d);
`endif
    end

    // State registers; reset drops every held payload at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= NOP_DW;
            occ_q        <= '0;
`ifdef PIPE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_DW;
            ready_q      <= 1'b0;
`else
            rst_done_q   <= 1'b0;
`endif
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            occ_q        <= occ_d;
`ifdef PIPE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
`else
            rst_done_q   <= 1'b1;
`endif
        end
    end

endmodule
